full_subtractor: RTL and testbench
==================================

// Module: full_subtractor
// PURPOSE
//  - Registered full subtractor: computes {bout,diff} = a - b - bin, one result per accepted input.
//  - Default WIDTH=1 is the classic 1-bit full subtractor cell.
//  - WIDTH>1 chains WIDTH 1-bit cells as a ripple-borrow subtractor.
//  - Used as the borrow-propagating arithmetic leaf in datapaths that need a registered difference plus borrow.
// PARAMETERS
//  - WIDTH  1  operand/difference width in bits (>=1)
// PORTS
//  - clk        in   1      single clock, rising-edge
//  - rst        in   1      synchronous, active-high reset
//  - in_valid   in   1      a/b/bin are valid this cycle
//  - a          in   WIDTH  minuend
//  - b          in   WIDTH  subtrahend
//  - bin        in   1      borrow-in, applied at bit 0
//  - diff       out  WIDTH  registered difference
//  - bout       out  1      registered borrow-out from MSB
//  - out_valid  out  1      diff/bout updated on the previous edge
//  - ovf        out  1      signed overflow; present only with FULL_SUBTRACTOR_OVF_EN
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high (rst).
//  - Bit cell i:
//      d[i]   = a[i] ^ b[i] ^ br[i]
//      br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i])
//      br[0] = bin; bout = br[WIDTH].
//  - Equivalently, {bout,diff} = {1'b0,a} - {1'b0,b} - bin, modulo 2^(WIDTH+1).
//    bout=1 iff a < b + bin (unsigned).
//  - Datapath is combinational into one output register stage: latency = 1 clk.
//  - On a rising edge with rst=0 and in_valid=1:
//      diff/bout (and ovf) load the new result; out_valid <= 1.
//  - On a rising edge with rst=0 and in_valid=0:
//      diff/bout/ovf hold their previous values; out_valid <= 0.
//  - Throughput is one result per clk; there is no backpressure and out_valid is not stalled.
//  - Reset: on any edge with rst=1, diff=0, bout=0, ovf=0, out_valid=0.
//    Reset takes priority over in_valid; an input presented during reset is discarded.
//  - Reset mid-stream: the result launched in the reset cycle is lost.
//    The first edge after rst falls accepts new data normally.
//  - Wrap-around: 0 - 0 - 1 gives diff = all ones, bout = 1.
//    (2^WIDTH-1) - 0 - 0 gives diff = all ones, bout = 0.
//  - X/Z on inputs while in_valid=0 must not affect the outputs.
// CONFIGURATION
//  - FULL_SUBTRACTOR_OVF_EN defined:
//      adds output ovf = br[WIDTH] ^ br[WIDTH-1], registered alongside diff.
//      ovf flags two's-complement overflow of a - b - bin.
//      For WIDTH=1, br[0]=bin, so ovf = bout ^ bin.
//  - FULL_SUBTRACTOR_OVF_EN undefined:
//      no ovf port and no ovf logic; all other behaviour is identical.
// TESTING
//  - Reset: hold rst=1 for 2 clk with in_valid=1, a=1, b=0, bin=0
//    -> diff=0, bout=0, out_valid=0 throughout.
//  - WIDTH=1 exhaustive, one vector per clk with in_valid=1, after the edge:
//      (a,b,bin) 000->d0 b0, 001->d1 b1, 010->d1 b1, 011->d0 b1,
//      100->d1 b0, 101->d0 b0, 110->d0 b0, 111->d1 b1.
//  - Hold: after a=1,b=0,bin=0 (d=1,b=0), drive in_valid=0 with a=0,b=1,bin=1
//    -> diff=1, bout=0 held; out_valid=0.
//  - WIDTH=8: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1.
//    a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
//  - With OVF_EN, WIDTH=8: a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1.
//    a=8'h05, b=8'h03, bin=0 -> ovf=0.
//  - Reset mid-stream: stream 3 vectors, assert rst on the 2nd
//    -> 2nd result lost, outputs 0 and out_valid=0; the 3rd result appears 1 clk after rst falls.

Source files
------------

// File: rtl/full_subtractor.sv
// full_subtractor: registered ripple-borrow subtractor, {bout,diff} = a - b - bin.
//
// WIDTH=1 is the classic 1-bit full subtractor cell. WIDTH>1 chains WIDTH cells
// with the borrow rippling from bit 0 up to the MSB. A single register stage
// follows the combinational datapath, so results appear one clock after the
// inputs are accepted.
//
// Optional feature macro: FULL_SUBTRACTOR_OVF_EN
//   When defined, adds the ovf output flagging two's-complement overflow of
//   a - b - bin (borrow into the MSB xor borrow out of the MSB).
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a/b/bin valid this cycle
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in at bit 0
//   diff       out  WIDTH  registered difference
//   bout       out  1      registered borrow-out of the MSB
//   ovf        out  1      registered signed overflow (FULL_SUBTRACTOR_OVF_EN only)
//   out_valid  out  1      diff/bout updated on the previous edge

module full_subtractor #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef FULL_SUBTRACTOR_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // ------------------------------------------------------------------
    // Combinational ripple-borrow chain
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] diff_c;
    logic             borrow_c;
`ifdef FULL_SUBTRACTOR_OVF_EN
    logic             borrow_msb_c;
`endif

    // The borrow is carried in a single variable stepped through the loop
    // rather than a vector, which keeps the chain free of self-referencing
    // vector bits.
    always_comb begin
        diff_c   = '0;
        borrow_c = bin;
`ifdef FULL_SUBTRACTOR_OVF_EN
        borrow_msb_c = bin;
`endif
        for (int i = 0; i < int'(WIDTH); i++) begin
`ifdef FULL_SUBTRACTOR_OVF_EN
            // Borrow into the MSB cell, needed for the overflow term.
            if (i == int'(WIDTH) - 1) begin
                borrow_msb_c = borrow_c;
            end
`endif
            diff_c[i] = a[i] ^ b[i] ^ borrow_c;
            borrow_c  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_c);
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             valid_q, valid_d;
`ifdef FULL_SUBTRACTOR_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Without in_valid the data registers hold; only the mux select depends
    // on in_valid, so garbage on a/b/bin while idle never reaches the flops.
    always_comb begin
        diff_d  = diff_q;
        bout_d  = bout_q;
        valid_d = 1'b0;
`ifdef FULL_SUBTRACTOR_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (in_valid) begin
            diff_d  = diff_c;
            bout_d  = borrow_c;
            valid_d = 1'b1;
`ifdef FULL_SUBTRACTOR_OVF_EN
            ovf_d   = borrow_c ^ borrow_msb_c;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q  <= '0;
            bout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef FULL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            valid_q <= valid_d;
`ifdef FULL_SUBTRACTOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign diff      = diff_q;
    assign bout      = bout_q;
    assign out_valid = valid_q;
`ifdef FULL_SUBTRACTOR_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Testbench for full_subtractor: drives a WIDTH=8 and a WIDTH=1 instance side
// by side. Each driven cycle pushes the expected post-edge outputs into a
// per-instance queue; a monitor pops and compares on every falling edge.

module tb_full_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v8, v1;
    logic [7:0] a8, b8;
    logic       bin8;
    logic [0:0] a1, b1;
    logic       bin1;

    logic [7:0] d8;
    logic       bo8, ovld8;
    logic [0:0] d1;
    logic       bo1, ovld1;
`ifdef FULL_SUBTRACTOR_OVF_EN
    logic       ov8, ov1;
`endif

    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .bin       (bin8),
        .diff      (d8),
        .bout      (bo8),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .ovf       (ov8),
`endif
        .out_valid (ovld8)
    );

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .bin       (bin1),
        .diff      (d1),
        .bout      (bo1),
`ifdef FULL_SUBTRACTOR_OVF_EN
        .ovf       (ov1),
`endif
        .out_valid (ovld1)
    );

    typedef struct packed {
        logic       o;
        logic [7:0] d;
        logic       b;
        logic       v;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t h8 = '0;
    exp_t h1 = '0;

    int checks = 0;
    int errors = 0;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t calc(input int w, input logic [7:0] av, input logic [7:0] bv,
                                  input logic bnv, input exp_t prev, input logic vld,
                                  input logic r);
        exp_t e;
        int   mask, half, ua, ub, res, sa, sb, s;
        if (r) return '0;
        if (!vld) begin
            e   = prev;
            e.v = 1'b0;
            return e;
        end
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        ua   = int'(av) & mask;
        ub   = int'(bv) & mask;
        res  = ua - ub - int'(bnv);
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        s    = sa - sb - int'(bnv);
        e.v  = 1'b1;
        e.d  = 8'(res & mask);
        e.b  = (res < 0);
        e.o  = (s < -half) || (s > half - 1);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic va, input logic [7:0] a8v,
                        input logic [7:0] b8v, input logic bin8v, input logic vb,
                        input logic a1v, input logic b1v, input logic bin1v);
        rst  = r;
        v8   = va;
        a8   = a8v;
        b8   = b8v;
        bin8 = bin8v;
        v1   = vb;
        a1   = a1v;
        b1   = b1v;
        bin1 = bin1v;
        h8 = calc(8, a8v, b8v, bin8v, h8, va, r);
        q8.push_back(h8);
        h1 = calc(1, {7'b0, a1v}, {7'b0, b1v}, bin1v, h1, vb, r);
        q1.push_back(h1);
        @(negedge clk);
    endtask

    // Monitor: outputs sampled on the falling edge after each driven edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("w8_out_valid", {31'b0, ovld8}, {31'b0, e.v});
                chk("w8_diff", {24'b0, d8}, {24'b0, e.d});
                chk("w8_bout", {31'b0, bo8}, {31'b0, e.b});
`ifdef FULL_SUBTRACTOR_OVF_EN
                chk("w8_ovf", {31'b0, ov8}, {31'b0, e.o});
`endif
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("w1_out_valid", {31'b0, ovld1}, {31'b0, e.v});
                chk("w1_diff", {31'b0, d1}, {31'b0, e.d[0]});
                chk("w1_bout", {31'b0, bo1}, {31'b0, e.b});
`ifdef FULL_SUBTRACTOR_OVF_EN
                chk("w1_ovf", {31'b0, ov1}, {31'b0, e.o});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held 2 clocks with a valid input presented: must be discarded.
        step(1, 1, 8'h01, 8'h00, 0, 1, 1, 0, 0);
        step(1, 1, 8'h01, 8'h00, 0, 1, 1, 0, 0);

        // WIDTH=1 exhaustive truth table, WIDTH=8 random alongside.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            kv = 3'(k);
            step(0, 1, 8'($urandom), 8'($urandom), 1'($urandom), 1, kv[2], kv[1], kv[0]);
        end

        // Hold: load d=1,b=0 then idle with different inputs on the pins.
        step(0, 1, 8'h01, 8'h00, 0, 1, 1, 0, 0);
        step(0, 0, 8'h00, 8'h01, 1, 0, 0, 1, 1);
        step(0, 0, 8'hAA, 8'h55, 0, 0, 1, 1, 1);

        // WIDTH=8 boundaries and overflow cases.
        step(0, 1, 8'h00, 8'h01, 0, 1, 0, 0, 1);
        step(0, 1, 8'h80, 8'h7F, 1, 1, 1, 1, 1);
        step(0, 1, 8'h80, 8'h01, 0, 1, 0, 1, 0);
        step(0, 1, 8'h05, 8'h03, 0, 1, 1, 0, 1);
        step(0, 1, 8'h00, 8'h00, 1, 1, 0, 0, 1);
        step(0, 1, 8'hFF, 8'h00, 0, 1, 1, 0, 0);
        step(0, 1, 8'h7F, 8'hFF, 1, 1, 0, 1, 1);

        // Reset mid-stream: 2nd vector lost, 3rd appears one clock after rst falls.
        step(0, 1, 8'h10, 8'h01, 0, 1, 1, 0, 1);
        step(1, 1, 8'h20, 8'h02, 0, 1, 0, 1, 0);
        step(0, 1, 8'h30, 8'h03, 1, 1, 1, 1, 0);
        step(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);

        // Randomized traffic with sparse resets and idle cycles.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        chk("w8_queue_drained", q8.size(), 0);
        chk("w1_queue_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
